// File: rtl/pa_pkg.sv
// Shared types for the skew feeder: FSM states, per-beat lane tags, lane slicing helpers.
package pa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pa_feed_state_e;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } pa_tag_t;

  // V and H elements of one lane travel together through a single skew register.
  localparam int LANE_BUSES = 2;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pa_skew_feeder_if.sv
// Operand source / processing array bundle for the skew feeder; the feeder uses the slave modport.
interface pa_skew_feeder_if #(
  parameter int SIZE_MAT       = 16,
  parameter int WIDTH_DATA     = 16,
  parameter int WIDTH_LBIT_CNT = 6,
  parameter int WIDTH_HBIT_CNT = 3
);

  logic                           start_i;
  logic [WIDTH_LBIT_CNT-1:0]      k_len_i;
  logic [WIDTH_HBIT_CNT-1:0]      n_tile_i;
  logic                           data_rdy_i;
  logic [SIZE_MAT*WIDTH_DATA-1:0] v_bus_i;
  logic [SIZE_MAT*WIDTH_DATA-1:0] h_bus_i;
  logic                           read_en_o;
  logic [SIZE_MAT*WIDTH_DATA-1:0] v_skew_o;
  logic [SIZE_MAT*WIDTH_DATA-1:0] h_skew_o;
  logic [SIZE_MAT-1:0]            vld_o;
  logic [SIZE_MAT-1:0]            first_o;
  logic [SIZE_MAT-1:0]            last_o;
  logic                           busy_o;
  logic                           done_o;

  modport master (
    output start_i, k_len_i, n_tile_i, data_rdy_i, v_bus_i, h_bus_i,
    input  read_en_o, v_skew_o, h_skew_o, vld_o, first_o, last_o, busy_o, done_o
  );

  modport slave (
    input  start_i, k_len_i, n_tile_i, data_rdy_i, v_bus_i, h_bus_i,
    output read_en_o, v_skew_o, h_skew_o, vld_o, first_o, last_o, busy_o, done_o
  );

endinterface

// File: rtl/pa_skew_lane.sv
// One skew lane: DEPTH-stage delay line; tags always shift, data only follows valid beats.
module pa_skew_lane
  import pa_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] src_data,
  input  pa_tag_t          src_tag,
  output logic [WIDTH-1:0] dst_data,
  output pa_tag_t          dst_tag
);

  logic [WIDTH-1:0] data_q [DEPTH];
  pa_tag_t          tag_q  [DEPTH];

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
  // NOTE: the data stages are reset too; the array must see all-zero lanes right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        data_q[j] <= '0;
        tag_q[j]  <= '0;
      end
    end else begin
      tag_q[0] <= src_tag;
      if (src_tag.vld) data_q[0] <= src_data;
      for (int j = 1; j < DEPTH; j++) begin
        tag_q[j] <= tag_q[j-1];
        if (tag_q[j-1].vld) data_q[j] <= data_q[j-1];
      end
    end
  end

  assign dst_data = data_q[DEPTH-1];
  assign dst_tag  = tag_q[DEPTH-1];

endmodule

// File: rtl/pa_skew_feeder.sv
// Operand feeder: pulls V/H beats from the source, tags tile boundaries, and diagonally skews lanes.
module pa_skew_feeder
  import pa_pkg::*;
#(
  parameter int SIZE_MAT       = 16,
  parameter int WIDTH_DATA     = 16,
  parameter int WIDTH_LBIT_CNT = 6,
  parameter int WIDTH_HBIT_CNT = 3
) (
  input logic              clk,
  input logic              rst,
  pa_skew_feeder_if.slave  bus
);

  localparam int WD      = WIDTH_DATA;
  localparam int WL      = WIDTH_LBIT_CNT;
  localparam int WH      = WIDTH_HBIT_CNT;
  localparam int DRAIN_W = $clog2(SIZE_MAT + 1);

  pa_feed_state_e     state_q;
  logic [WL-1:0]      k_q;
  logic [WH-1:0]      tile_q;
  logic [WL:0]        k_len_q;
  logic [WH:0]        n_tile_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               done_q;

  logic issue;
  logic k_last;
  logic tile_last;

  assign issue     = (state_q == RUN) && bus.data_rdy_i;
  // Lengths are held one bit wider so the 0 = maximum encoding needs no special casing here.
  assign k_last    = ({1'b0, k_q} == k_len_q - (WL+1)'(1));
  assign tile_last = ({1'b0, tile_q} == n_tile_q - (WH+1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      tile_q   <= '0;
      k_len_q  <= '0;
      n_tile_q <= '0;
      drain_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            k_len_q  <= (bus.k_len_i == '0)  ? {1'b1, {WL{1'b0}}} : {1'b0, bus.k_len_i};
            n_tile_q <= (bus.n_tile_i == '0) ? {1'b1, {WH{1'b0}}} : {1'b0, bus.n_tile_i};
            k_q      <= '0;
            tile_q   <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (k_last) begin
              k_q <= '0;
              if (tile_last) begin
                drain_q <= '0;
                state_q <= DRAIN;
              end else begin
                tile_q <= tile_q + WH'(1);
              end
            end else begin
              k_q <= k_q + WL'(1);
            end
          end
        end
        DRAIN: begin
          // The last lane shows its final beat SIZE_MAT+1 cycles after the last issue.
          if (drain_q == DRAIN_W'(SIZE_MAT)) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pa_tag_t                cap_tag;
  logic [SIZE_MAT*WD-1:0] cap_v;
  logic [SIZE_MAT*WD-1:0] cap_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_tag <= '0;
      cap_v   <= '0;
      cap_h   <= '0;
    end else begin
      cap_tag.vld   <= issue;
      cap_tag.first <= issue && (k_q == '0);
      cap_tag.last  <= issue && k_last;
      if (issue) begin
        cap_v <= bus.v_bus_i;
        cap_h <= bus.h_bus_i;
      end
    end
  end

  logic [LANE_BUSES*WD-1:0] lane_data [SIZE_MAT];
  pa_tag_t                  lane_tag  [SIZE_MAT];

  for (genvar i = 0; i < SIZE_MAT; i++) begin : g_lane
    pa_skew_lane #(
      .DEPTH (i + 1),
      .WIDTH (LANE_BUSES * WD)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .src_data ({cap_h[i*WD +: WD], cap_v[i*WD +: WD]}),
      .src_tag  (cap_tag),
      .dst_data (lane_data[i]),
      .dst_tag  (lane_tag[i])
    );
  end

  logic [SIZE_MAT*WD-1:0] v_skew;
  logic [SIZE_MAT*WD-1:0] h_skew;
  logic [SIZE_MAT-1:0]    vld;
  logic [SIZE_MAT-1:0]    first;
  logic [SIZE_MAT-1:0]    last;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    v_skew = '0;
    h_skew = '0;
    vld    = '0;
    first  = '0;
    last   = '0;
    for (int i = 0; i < SIZE_MAT; i++) begin
      v_skew[lane_lsb(i, WD) +: WD] = lane_data[i][0 +: WD];
      h_skew[lane_lsb(i, WD) +: WD] = lane_data[i][WD +: WD];
      vld[i]   = lane_tag[i].vld;
      first[i] = lane_tag[i].first;
      last[i]  = lane_tag[i].last;
    end
  end

  assign bus.read_en_o = issue;
  assign bus.v_skew_o  = v_skew;
  assign bus.h_skew_o  = h_skew;
  assign bus.vld_o     = vld;
  assign bus.first_o   = first;
  assign bus.last_o    = last;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_pa_skew_feeder.sv
// Scoreboard bench for pa_skew_feeder: the driver predicts each lane's beat stream, a monitor checks it.
module tb_pa_skew_feeder;

  localparam int N  = 16;
  localparam int WD = 16;
  localparam int WL = 6;
  localparam int WH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pa_skew_feeder_if #(
    .SIZE_MAT(N), .WIDTH_DATA(WD), .WIDTH_LBIT_CNT(WL), .WIDTH_HBIT_CNT(WH)
  ) bus ();

  pa_skew_feeder #(
    .SIZE_MAT(N), .WIDTH_DATA(WD), .WIDTH_LBIT_CNT(WL), .WIDTH_HBIT_CNT(WH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [WD-1:0] v;
    logic [WD-1:0] h;
    bit            first;
    bit            last;
    int            cyc;
  } exp_t;

  exp_t          exp_q  [N][$];
  logic [WD-1:0] held_v [N];
  logic [WD-1:0] held_h [N];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int done_cyc = -1;
  bit mon_en   = 1'b0;
  bit rd_exp   = 1'b0;
  bit busy_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every cycle against the expectations the driver queued.
  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (mon_en) begin
      check("read_en", bus.read_en_o, rd_exp);
      check("busy", bus.busy_o, busy_exp);
      check("done", bus.done_o, cyc == done_cyc);
      for (int i = 0; i < N; i++) begin
        ev = (exp_q[i].size() > 0) && (exp_q[i][0].cyc == cyc);
        check($sformatf("vld_l%0d", i), bus.vld_o[i], ev);
        if (ev) begin
          e = exp_q[i].pop_front();
          held_v[i] = e.v;
          held_h[i] = e.h;
          check($sformatf("first_l%0d", i), bus.first_o[i], e.first);
          check($sformatf("last_l%0d", i), bus.last_o[i], e.last);
        end else begin
          check($sformatf("first_idle_l%0d", i), bus.first_o[i], 1'b0);
          check($sformatf("last_idle_l%0d", i), bus.last_o[i], 1'b0);
        end
        check($sformatf("v_l%0d", i), bus.v_skew_o[i*WD +: WD], held_v[i]);
        check($sformatf("h_l%0d", i), bus.h_skew_o[i*WD +: WD], held_h[i]);
        while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) void'(exp_q[i].pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"},    bus.vld_o,     '0);
    check({tag, "_first"},  bus.first_o,   '0);
    check({tag, "_last"},   bus.last_o,    '0);
    check({tag, "_v"},      bus.v_skew_o,  '0);
    check({tag, "_h"},      bus.h_skew_o,  '0);
    check({tag, "_busy"},   bus.busy_o,    1'b0);
    check({tag, "_done"},   bus.done_o,    1'b0);
    check({tag, "_rd"},     bus.read_en_o, 1'b0);
  endtask

  // rdy_mode: 0 always ready, 1 alternate 1/0, 2 random. pat: v lane j = j + beat.
  task automatic run_job(input int kl_code, input int nt_code, input int rdy_mode,
                         input bit pat, input bit restart_mid, input bit reset_in_drain);
    int   kl, nt, total, issued, last_cyc, guard;
    bit   rdy;
    exp_t e;
    logic [N*WD-1:0] vv, hh;
    kl       = (kl_code == 0) ? (1 << WL) : kl_code;
    nt       = (nt_code == 0) ? (1 << WH) : nt_code;
    total    = kl * nt;
    issued   = 0;
    guard    = 0;
    last_cyc = 0;

    @(posedge clk); #1;
    bus.start_i    = 1'b1;
    bus.k_len_i    = WL'(kl_code);
    bus.n_tile_i   = WH'(nt_code);
    bus.data_rdy_i = 1'b0;
    rd_exp         = 1'b0;
    busy_exp       = 1'b0;
    @(posedge clk); #1;
    bus.start_i  = 1'b0;
    bus.k_len_i  = WL'($urandom);
    bus.n_tile_i = WH'($urandom);

    while (issued < total && guard < 4000) begin
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      for (int j = 0; j < N; j++) begin
        vv[j*WD +: WD] = pat ? WD'(j + issued) : WD'($urandom);
        hh[j*WD +: WD] = WD'($urandom);
      end
      bus.v_bus_i    = vv;
      bus.h_bus_i    = hh;
      bus.data_rdy_i = rdy;
      rd_exp         = rdy;
      busy_exp       = 1'b1;
      if (restart_mid && issued == total / 2) begin
        bus.start_i  = 1'b1;
        bus.k_len_i  = WL'(kl_code + 1);
        bus.n_tile_i = WH'(nt_code + 1);
      end
      if (rdy) begin
        for (int i = 0; i < N; i++) begin
          e.v     = vv[i*WD +: WD];
          e.h     = hh[i*WD +: WD];
          e.first = (issued % kl == 0);
          e.last  = (issued % kl == kl - 1);
          e.cyc   = cyc + 2 + i;
          exp_q[i].push_back(e);
        end
        last_cyc = cyc;
        issued++;
      end
      guard++;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
    end

    bus.data_rdy_i = 1'($urandom_range(0, 1));
    rd_exp         = 1'b0;
    done_cyc       = last_cyc + N + 2;

    if (reset_in_drain) begin
      repeat (6) @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        exp_q[i].delete();
        held_v[i] = '0;
        held_h[i] = '0;
      end
      busy_exp = 1'b0;
      done_cyc = -1;
      rst      = 1'b1;
      #1;
      check_all_zero("rst_drain");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (N + 4) @(posedge clk);
      #1;
    end else begin
      while (cyc <= done_cyc) begin
        busy_exp = (cyc < done_cyc);
        @(posedge clk); #1;
      end
      busy_exp = 1'b0;
    end
    bus.data_rdy_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst            = 1'b0;
    bus.start_i    = 1'b0;
    bus.k_len_i    = '0;
    bus.n_tile_i   = '0;
    bus.data_rdy_i = 1'b0;
    bus.v_bus_i    = '0;
    bus.h_bus_i    = '0;
    for (int i = 0; i < N; i++) begin
      held_v[i] = '0;
      held_h[i] = '0;
    end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #1 rst = 1'b0;
    mon_en = 1'b1;

    run_job(16, 1, 0, 1'b1, 1'b0, 1'b0);  // full tile, patterned lanes
    run_job(4,  2, 1, 1'b0, 1'b0, 1'b0);  // alternating stalls
    run_job(1,  0, 0, 1'b0, 1'b0, 1'b0);  // k_len=1, 8 tiles
    run_job(6,  3, 2, 1'b0, 1'b1, 1'b0);  // start pulsed mid-run
    run_job(5,  2, 0, 1'b0, 1'b0, 1'b1);  // reset mid-drain
    run_job(3,  1, 0, 1'b1, 1'b0, 1'b0);  // normal job after reset
    run_job(0,  1, 2, 1'b0, 1'b0, 1'b0);  // max K depth
    run_job(2,  0, 2, 1'b0, 1'b0, 1'b0);  // max tile count
    repeat (3) run_job($urandom_range(1, 8), $urandom_range(1, 4), 2, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
